// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port integer register file.
//   XLEN_DEF  default register width
//   NREG_DEF  default number of architectural registers
//   REG_ZERO  index of the hardwired-zero register
package regfile_mp_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int REG_ZERO = 0;

  // Index width for a register file of n entries (n is a power of two, >= 2).
  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback (master) and the register file (slave).
//   we/waddr/wdata/wclr  per write port, port p at [p*AW +: AW] / [p*XLEN +: XLEN]
//   raddr/rdata/rbusy    per read port, combinational read data and busy view
//   sb_set/sb_idx        decode marks a destination register busy
//   busy                 registered scoreboard vector
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  localparam int AW = idx_width(NREG);

  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NWR-1:0]      wclr;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                sb_set;
  logic [AW-1:0]       sb_idx;
  logic [NREG-1:0]     busy;

  modport master (
    output we, waddr, wdata, wclr, raddr, sb_set, sb_idx,
    input  rdata, rbusy, busy
  );

  modport slave (
    input  we, waddr, wdata, wclr, raddr, sb_set, sb_idx,
    output rdata, rbusy, busy
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst        clock, synchronous active-high reset
//   we/waddr/wclr   writeback ports; a write with wclr clears the busy bit of its index
//   sb_set/sb_idx   decode marks a destination busy
//   busy            registered busy vector (bit 0 always 0)
//   clr_hit         combinational per-index clear requests this cycle (for read bypass)
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = 1,
  parameter int AW   = idx_width(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NWR-1:0]    wclr,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_idx,
  output logic [NREG-1:0]   busy,
  output logic [NREG-1:0]   clr_hit
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    clr_hit = '0;
    for (int p = 0; p < NWR; p++) begin
      if (we[p] && wclr[p]) clr_hit[waddr[p*AW +: AW]] = 1'b1;
    end
    clr_hit[REG_ZERO] = 1'b0;
  end

  // Set after clear: a new producer issuing while the old one writes back
  // must leave the register busy.
  always_comb begin
    busy_d = busy_q & ~clr_hit;
    if (sb_set) busy_d[sb_idx] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with optional write-to-read
// bypass and a busy scoreboard for decode hazard stalls.
//   clk   clock, all state updates on the rising edge
//   rst   synchronous, active-high reset (clears registers and scoreboard)
//   rf    regfile_mp_if slave: write ports, read ports, scoreboard set, busy
// Parameters: XLEN width, NREG depth (power of 2), NRD read ports (1..4),
// NWR write ports (1..2), BYPASS forwards same-cycle write data to reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  regfile_mp_if.slave rf
);

  localparam int AW = idx_width(NREG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     clr_hit;
  logic [NRD*XLEN-1:0] rdata_c;
  logic [NRD-1:0]      rbusy_c;

  // Later ports overwrite earlier ones, so the highest write port wins on
  // an index collision.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NWR; p++) begin
      if (rf.we[p]) regs_d[rf.waddr[p*AW +: AW]] = rf.wdata[p*XLEN +: XLEN];
    end
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  regfile_mp_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .we      (rf.we),
    .waddr   (rf.waddr),
    .wclr    (rf.wclr),
    .sb_set  (rf.sb_set),
    .sb_idx  (rf.sb_idx),
    .busy    (busy),
    .clr_hit (clr_hit)
  );

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    rdata_c = '0;
    rbusy_c = '0;
    ra      = '0;
    val     = '0;
    for (int r = 0; r < NRD; r++) begin
      ra  = rf.raddr[r*AW +: AW];
      val = regs_q[ra];
      if (BYPASS) begin
        for (int p = 0; p < NWR; p++) begin
          if (rf.we[p] && (rf.waddr[p*AW +: AW] == ra)) val = rf.wdata[p*XLEN +: XLEN];
        end
      end
      if (ra == AW'(REG_ZERO)) val = '0;
      rdata_c[r*XLEN +: XLEN] = val;
      // A writeback clearing this register this cycle releases the reader
      // immediately, since the data is forwarded in the same cycle.
      rbusy_c[r] = busy[ra] & ~(BYPASS & clr_hit[ra]);
    end
  end

  assign rf.rdata = rdata_c;
  assign rf.rbusy = rbusy_c;
  assign rf.busy  = busy;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) if_a ();
  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) if_b ();

  // Second instance (no bypass) sees exactly the same stimulus.
  assign if_b.we     = if_a.we;
  assign if_b.waddr  = if_a.waddr;
  assign if_b.wdata  = if_a.wdata;
  assign if_b.wclr   = if_a.wclr;
  assign if_b.raddr  = if_a.raddr;
  assign if_b.sb_set = if_a.sb_set;
  assign if_b.sb_idx = if_a.sb_idx;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst(rst), .rf(if_a));
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst(rst), .rf(if_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [1:0]  wclr;
    logic        sbs;
    logic [4:0]  sbi;
    logic [4:0]  ra0, ra1;
    logic [63:0] ea0, ea1, eb0;
    logic [1:0]  erba, erbb;
    logic [31:0] ebusy;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
    input logic [63:0] wd0, input logic [63:0] wd1, input logic [1:0] wclr,
    input logic sbs, input logic [4:0] sbi, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [63:0] ea0, input logic [63:0] ea1, input logic [63:0] eb0,
    input logic [1:0] erba, input logic [1:0] erbb, input logic [31:0] ebusy);
    vec_t v;
    v.rst = r; v.we = we; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
    v.wclr = wclr; v.sbs = sbs; v.sbi = sbi; v.ra0 = ra0; v.ra1 = ra1;
    v.ea0 = ea0; v.ea1 = ea1; v.eb0 = eb0; v.erba = erba; v.erbb = erbb; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [63:0] wd0, input logic [63:0] wd1, input logic [1:0] wclr,
                       input logic sbs, input logic [4:0] sbi, input logic [19:0] ra);
    if_a.we     = we;
    if_a.waddr  = {wa1, wa0};
    if_a.wdata  = {wd1, wd0};
    if_a.wclr   = wclr;
    if_a.sb_set = sbs;
    if_a.sb_idx = sbi;
    if_a.raddr  = ra;
  endtask

  vec_t vt [18];

  logic [63:0] mem [NREG];
  logic [31:0] busy_m;

  initial begin
    // Expected values are pre-edge (combinational reads, registered busy).
    vt[0]  = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 0,  0,  5,  0, 64'h0,    64'h0,    64'h0,    2'b00, 2'b00, 32'h0);
    vt[1]  = mk(0, 2'b01,  5,  0, 64'hDEAD, 64'h0,  2'b00, 0,  0,  5,  0, 64'hDEAD, 64'h0,    64'h0,    2'b00, 2'b00, 32'h0);
    vt[2]  = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 0,  0,  5,  0, 64'hDEAD, 64'h0,    64'hDEAD, 2'b00, 2'b00, 32'h0);
    vt[3]  = mk(0, 2'b01,  0,  0, 64'hFFFF, 64'h0,  2'b00, 1,  0,  0,  5, 64'h0,    64'hDEAD, 64'h0,    2'b00, 2'b00, 32'h0);
    vt[4]  = mk(0, 2'b11,  7,  7, 64'h11,   64'h22, 2'b00, 0,  0,  7,  5, 64'h22,   64'hDEAD, 64'h0,    2'b00, 2'b00, 32'h0);
    vt[5]  = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 1,  3,  7,  3, 64'h22,   64'h0,    64'h22,   2'b00, 2'b00, 32'h0);
    vt[6]  = mk(0, 2'b01,  3,  0, 64'h33,   64'h0,  2'b01, 1,  3,  3,  7, 64'h33,   64'h22,   64'h0,    2'b00, 2'b01, 32'h8);
    vt[7]  = mk(0, 2'b10,  0,  3, 64'h0,    64'h44, 2'b10, 0,  0,  3,  3, 64'h44,   64'h44,   64'h33,   2'b00, 2'b11, 32'h8);
    vt[8]  = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 1,  9,  3,  9, 64'h44,   64'h0,    64'h44,   2'b00, 2'b00, 32'h0);
    vt[9]  = mk(0, 2'b00,  9,  0, 64'h0,    64'h0,  2'b01, 0,  0,  9,  9, 64'h0,    64'h0,    64'h0,    2'b11, 2'b11, 32'h200);
    vt[10] = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 1,  9,  9,  0, 64'h0,    64'h0,    64'h0,    2'b01, 2'b01, 32'h200);
    vt[11] = mk(0, 2'b01,  9,  0, 64'h99,   64'h0,  2'b01, 0,  0,  9,  9, 64'h99,   64'h99,   64'h0,    2'b00, 2'b11, 32'h200);
    vt[12] = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 1, 12,  9, 12, 64'h99,   64'h0,    64'h99,   2'b00, 2'b00, 32'h0);
    vt[13] = mk(0, 2'b11, 12, 12, 64'hA,    64'hB,  2'b01, 0,  0, 12,  0, 64'hB,    64'h0,    64'h0,    2'b00, 2'b01, 32'h1000);
    vt[14] = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 0,  0, 12,  9, 64'hB,    64'h99,   64'hB,    2'b00, 2'b00, 32'h0);
    vt[15] = mk(0, 2'b01,  5,  0, 64'h1234, 64'h0,  2'b00, 1,  4,  5,  0, 64'h1234, 64'h0,    64'hDEAD, 2'b00, 2'b00, 32'h0);
    vt[16] = mk(1, 2'b01,  6,  0, 64'h66,   64'h0,  2'b00, 1,  8,  5,  4, 64'h1234, 64'h0,    64'h1234, 2'b10, 2'b10, 32'h10);
    vt[17] = mk(0, 2'b00,  0,  0, 64'h0,    64'h0,  2'b00, 0,  0,  5,  6, 64'h0,    64'h0,    64'h0,    2'b00, 2'b00, 32'h0);

    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 2'b00, 1'b0, 0, 20'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    #3;
    chk("reset_busy_a", 64'(if_a.busy), 64'h0);
    chk("reset_busy_b", 64'(if_b.busy), 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      rst = vt[i].rst;
      drive(vt[i].we, vt[i].wa0, vt[i].wa1, vt[i].wd0, vt[i].wd1, vt[i].wclr,
            vt[i].sbs, vt[i].sbi, {vt[i].ra1, vt[i].ra0, vt[i].ra1, vt[i].ra0});
      #3;
      chk($sformatf("v%0d_rdata_a0", i), if_a.rdata[0 +: 64],   vt[i].ea0);
      chk($sformatf("v%0d_rdata_a1", i), if_a.rdata[64 +: 64],  vt[i].ea1);
      chk($sformatf("v%0d_rdata_a2", i), if_a.rdata[128 +: 64], vt[i].ea0);
      chk($sformatf("v%0d_rdata_b0", i), if_b.rdata[0 +: 64],   vt[i].eb0);
      chk($sformatf("v%0d_rbusy_a", i),  64'(if_a.rbusy[1:0]),  64'(vt[i].erba));
      chk($sformatf("v%0d_rbusy_b", i),  64'(if_b.rbusy[1:0]),  64'(vt[i].erbb));
      chk($sformatf("v%0d_busy_a", i),   64'(if_a.busy),        64'(vt[i].ebusy));
      chk($sformatf("v%0d_busy_b", i),   64'(if_b.busy),        64'(vt[i].ebusy));
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Random 2W/4R traffic on a narrow index range to force collisions.
    for (int k = 0; k < NREG; k++) mem[k] = '0;
    busy_m = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0]  we, wclr;
      logic [4:0]  wa [2];
      logic [63:0] wd [2];
      logic        sbs;
      logic [4:0]  sbi;
      logic [4:0]  ra [4];
      logic [63:0] exp_a, exp_b;
      logic [3:0]  erb_a, erb_b;
      logic [31:0] clr;
      we    = 2'($urandom_range(0, 3));
      wclr  = 2'($urandom_range(0, 3));
      wa[0] = 5'($urandom_range(0, 7));
      wa[1] = 5'($urandom_range(0, 7));
      wd[0] = {$urandom, $urandom};
      wd[1] = {$urandom, $urandom};
      sbs   = ($urandom_range(0, 2) == 0);
      sbi   = 5'($urandom_range(0, 7));
      for (int r = 0; r < 4; r++) ra[r] = 5'($urandom_range(0, 7));
      drive(we, wa[0], wa[1], wd[0], wd[1], wclr, sbs, sbi, {ra[3], ra[2], ra[1], ra[0]});
      #3;
      clr = '0;
      for (int p = 0; p < 2; p++)
        if (we[p] && wclr[p] && wa[p] != 0) clr[wa[p]] = 1'b1;
      for (int r = 0; r < 4; r++) begin
        exp_b = (ra[r] == 0) ? 64'h0 : mem[ra[r]];
        exp_a = exp_b;
        if (ra[r] != 0) begin
          if (we[1] && wa[1] == ra[r])      exp_a = wd[1];
          else if (we[0] && wa[0] == ra[r]) exp_a = wd[0];
        end
        erb_a[r] = busy_m[ra[r]] && !clr[ra[r]];
        erb_b[r] = busy_m[ra[r]];
        chk($sformatf("rnd%0d_rdata_a%0d", cyc, r), if_a.rdata[r*64 +: 64], exp_a);
        chk($sformatf("rnd%0d_rdata_b%0d", cyc, r), if_b.rdata[r*64 +: 64], exp_b);
      end
      chk($sformatf("rnd%0d_rbusy_a", cyc), 64'(if_a.rbusy), 64'(erb_a));
      chk($sformatf("rnd%0d_rbusy_b", cyc), 64'(if_b.rbusy), 64'(erb_b));
      chk($sformatf("rnd%0d_busy_a", cyc),  64'(if_a.busy),  64'(busy_m));
      chk($sformatf("rnd%0d_busy_b", cyc),  64'(if_b.busy),  64'(busy_m));
      for (int p = 0; p < 2; p++)
        if (we[p] && wa[p] != 0) mem[wa[p]] = wd[p];
      busy_m = busy_m & ~clr;
      if (sbs && sbi != 0) busy_m[sbi] = 1'b1;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
